// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler: owns the single pixel-write port of the 320x240 VGA
// adapter. A full-screen clear engine has absolute priority; two rectangle
// requesters share the remaining time round-robin. One pixel per clock, jobs
// run to completion, all outputs registered.
//
// Handshake: req[i] is a level request that must stay high until gnt[i] is
// seen. Requests are only sampled in IDLE; the job's corner, size and colour
// are captured on the same edge that raises gnt[i], so the requester may
// change them right after. gnt[i] and done[i] are single-cycle pulses, and
// no flow control exists towards the adapter.
module vga_draw_scheduler #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear_req,
  input  logic [2:0] clear_colour,
  input  logic [1:0] req,
  input  logic [8:0] rx0_0,
  input  logic [7:0] ry0_0,
  input  logic [8:0] rw_0,
  input  logic [7:0] rh_0,
  input  logic [2:0] rcol_0,
  input  logic [8:0] rx0_1,
  input  logic [7:0] ry0_1,
  input  logic [8:0] rw_1,
  input  logic [7:0] rh_1,
  input  logic [2:0] rcol_1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       clear_done,
  output logic       busy,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RECT  = 2'd2
  } state_t;

  localparam logic [9:0] H_LIM = 10'(H_RES);
  localparam logic [8:0] V_LIM = 9'(V_RES);

  state_t     state_q, state_d;
  logic       last_q, last_d;      // requester granted most recently
  logic       owner_q, owner_d;    // requester that owns the running rect
  logic       empty_q, empty_d;    // running rect has zero width or height
  logic [9:0] cx_q, cx_d;          // current sweep x, wide so it never wraps
  logic [8:0] cy_q, cy_d;          // current sweep y
  logic [9:0] x0_q, x0_d;          // left edge the sweep returns to
  logic [9:0] xe_q, xe_d;          // last x of a row
  logic [8:0] ye_q, ye_d;          // last row
  logic [2:0] col_q, col_d;

  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic       clear_done_q, clear_done_d;
  logic       busy_q, busy_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;

  logic       sel;
  logic [8:0] sx0, sw;
  logic [7:0] sy0, sh;
  logic [2:0] scol;
  logic [9:0] nx;
  logic [8:0] ny;
  logic       row_end, last_pix;

  assign sx0  = sel ? rx0_1  : rx0_0;
  assign sy0  = sel ? ry0_1  : ry0_0;
  assign sw   = sel ? rw_1   : rw_0;
  assign sh   = sel ? rh_1   : rh_0;
  assign scol = sel ? rcol_1 : rcol_0;

  assign row_end  = (cx_q == xe_q);
  assign last_pix = empty_q || (row_end && (cy_q == ye_q));
  assign nx       = row_end ? x0_q : cx_q + 10'd1;
  assign ny       = row_end ? cy_q + 9'd1 : cy_q;

  // Round-robin pick: a lone request wins outright, a tie goes to the other side.
  always_comb begin
    sel = (req == 2'b11) ? ~last_q : req[1];
  end

  // Next-state and next-output logic for arbitration and the raster sweep.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    empty_d      = empty_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    x0_d         = x0_q;
    xe_d         = xe_q;
    ye_d         = ye_q;
    col_d        = col_q;
    gnt_d        = 2'b00;
    done_d       = 2'b00;
    clear_done_d = 1'b0;
    busy_d       = busy_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (clear_req) begin
          state_d  = S_CLEAR;
          empty_d  = 1'b0;
          cx_d     = 10'd0;
          cy_d     = 9'd0;
          x0_d     = 10'd0;
          xe_d     = H_LIM - 10'd1;
          ye_d     = V_LIM - 9'd1;
          col_d    = clear_colour;
          busy_d   = 1'b1;
          x_d      = 9'd0;
          y_d      = 8'd0;
          colour_d = clear_colour;
          plot_d   = 1'b1;
        end else if (req != 2'b00) begin
          state_d = S_RECT;
          owner_d = sel;
          last_d  = sel;
          gnt_d   = sel ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          empty_d = (sw == 9'd0) || (sh == 8'd0);
          cx_d    = {1'b0, sx0};
          cy_d    = {1'b0, sy0};
          x0_d    = {1'b0, sx0};
          xe_d    = {1'b0, sx0} + {1'b0, sw} - 10'd1;
          ye_d    = {1'b0, sy0} + {1'b0, sh} - 9'd1;
          col_d   = scol;
          if (!empty_d) begin
            x_d      = sx0;
            y_d      = sy0;
            colour_d = scol;
            plot_d   = ({1'b0, sx0} < H_LIM) && ({1'b0, sy0} < V_LIM);
          end
        end
      end
      S_CLEAR, S_RECT: begin
        if (last_pix) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (state_q == S_CLEAR) clear_done_d = 1'b1;
          else                    done_d = owner_q ? 2'b10 : 2'b01;
        end else begin
          cx_d     = nx;
          cy_d     = ny;
          x_d      = nx[8:0];
          y_d      = ny[7:0];
          colour_d = col_q;
          plot_d   = (nx < H_LIM) && (ny < V_LIM);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, job context and registered outputs; reset aborts any job silently.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      empty_q      <= 1'b0;
      cx_q         <= 10'd0;
      cy_q         <= 9'd0;
      x0_q         <= 10'd0;
      xe_q         <= 10'd0;
      ye_q         <= 9'd0;
      col_q        <= 3'd0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
      x_q          <= 9'd0;
      y_q          <= 8'd0;
      colour_q     <= 3'd0;
      plot_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      empty_q      <= empty_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      x0_q         <= x0_d;
      xe_q         <= xe_d;
      ye_q         <= ye_d;
      col_q        <= col_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      clear_done_q <= clear_done_d;
      busy_q       <= busy_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign clear_done = clear_done_q;
  assign busy       = busy_q;
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign dbg_state  = state_q;

endmodule
